// File: rtl/controle_pc.sv
// controle_pc: program-counter update stage of the multicycle datapath.
// Runs the shared 10-phase instruction counter, latches the branch decision
// and target mid-instruction, commits the next PC once per instruction and
// raises a sticky halt when the next PC would leave program memory.
module controle_pc #(
   parameter int unsigned PC_RESET     = 0,
   parameter int unsigned PC_MAX       = 31,
   parameter int unsigned FASE_DECISAO = 5,
   parameter int unsigned FASE_ESCRITA = 9
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] entrada_mux,
   input  logic        branch,
   input  logic        zero,
   input  logic [2:0]  funct3,
   output logic [31:0] estado_pc,
   output logic [3:0]  fase,
   output logic        desvio_tomado,
   output logic        halt
);

   localparam logic [3:0]  FASE_ULTIMA = 4'd9;
   localparam logic [3:0]  FASE_DEC    = 4'(FASE_DECISAO);
   localparam logic [3:0]  FASE_ESC    = 4'(FASE_ESCRITA);
   localparam logic [31:0] PC_LIMITE   = 32'(PC_MAX);
   localparam logic [31:0] PC_INICIAL  = 32'(PC_RESET);

   localparam logic [2:0]  F3_BEQ = 3'b000;
   localparam logic [2:0]  F3_BNE = 3'b001;

   logic [31:0] pc_q, pc_d;
   logic [31:0] alvo_q, alvo_d;
   logic [3:0]  fase_q, fase_d;
   logic        desvio_q, desvio_d;
   logic        halt_q, halt_d;

   logic        tomado;
   logic [31:0] proximo;

   // Branch condition and candidate next PC, both purely combinational.
   always_comb begin
      tomado  = branch & (((funct3 == F3_BEQ) & zero) | ((funct3 == F3_BNE) & ~zero));
      proximo = desvio_q ? alvo_q : pc_q + 32'd1;
   end

   // Next-state logic: phase advance, decision sampling, PC commit, halt.
   always_comb begin
      // NOTE: every _d starts as its _q so no path leaves a signal unassigned,
      // which would otherwise infer a latch.
      pc_d     = pc_q;
      alvo_d   = alvo_q;
      fase_d   = fase_q;
      desvio_d = desvio_q;
      halt_d   = halt_q;

      if (!halt_q) begin
         if (fase_q == FASE_ULTIMA) begin
            fase_d   = 4'd0;
            desvio_d = 1'b0;
         end else begin
            fase_d = fase_q + 4'd1;
         end

         if (fase_q == FASE_DEC) begin
            desvio_d = tomado;
            alvo_d   = entrada_mux;
         end

         if (fase_q == FASE_ESC) begin
            if (proximo > PC_LIMITE) begin
               // Leaving program memory: freeze everything at the write phase.
               halt_d   = 1'b1;
               fase_d   = fase_q;
               desvio_d = desvio_q;
            end else begin
               pc_d = proximo;
            end
         end
      end
   end

   // State registers; synchronous reset wins over commit and halt.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      if (reset) begin
         pc_q     <= PC_INICIAL;
         alvo_q   <= 32'd0;
         fase_q   <= 4'd0;
         desvio_q <= 1'b0;
         halt_q   <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         alvo_q   <= alvo_d;
         fase_q   <= fase_d;
         desvio_q <= desvio_d;
         halt_q   <= halt_d;
      end
   end

   assign estado_pc     = pc_q;
   assign fase          = fase_q;
   assign desvio_tomado = desvio_q;
   assign halt          = halt_q;

endmodule

// File: tb/tb_controle_pc.sv
// tb_controle_pc: drives directed and randomized instructions into controle_pc
// and compares every output against an instruction-level reference model on
// every falling edge, plus literal expectations at key scenario points.
module tb_controle_pc;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] entrada_mux = 32'd0;
   logic        branch = 1'b0;
   logic        zero = 1'b0;
   logic [2:0]  funct3 = 3'd0;
   logic [31:0] estado_pc;
   logic [3:0]  fase;
   logic        desvio_tomado;
   logic        halt;

   int total = 0;
   int bad   = 0;
   bit started = 1'b0;

   controle_pc dut (
      .clock         (clock),
      .reset         (reset),
      .entrada_mux   (entrada_mux),
      .branch        (branch),
      .zero          (zero),
      .funct3        (funct3),
      .estado_pc     (estado_pc),
      .fase          (fase),
      .desvio_tomado (desvio_tomado),
      .halt          (halt)
   );

   always #5 clock = ~clock;

   // Reference model: what one instruction does, phase by phase.
   logic [31:0] m_pc = 32'd0;
   logic [31:0] m_alvo = 32'd0;
   int          m_fase = 0;
   logic        m_taken = 1'b0;
   logic        m_halt = 1'b0;

   always @(posedge clock) begin
      logic [31:0] nxt;
      if (reset) begin
         m_pc = 32'd0; m_alvo = 32'd0; m_fase = 0; m_taken = 1'b0; m_halt = 1'b0;
      end else if (!m_halt) begin
         if (m_fase == 5) begin
            case (funct3)
               3'b000:  m_taken = branch && zero;
               3'b001:  m_taken = branch && !zero;
               default: m_taken = 1'b0;
            endcase
            m_alvo = entrada_mux;
         end
         if (m_fase == 9) begin
            nxt = m_taken ? m_alvo : m_pc + 32'd1;
            if (nxt > 32'd31) m_halt = 1'b1;
            else              m_pc = nxt;
         end
         if (!m_halt) begin
            m_fase = (m_fase + 1) % 10;
            if (m_fase == 0) m_taken = 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model.
   always @(negedge clock) begin
      if (started) begin
         check("estado_pc", estado_pc, m_pc);
         check("fase", {28'd0, fase}, 32'(m_fase));
         check("desvio_tomado", {31'd0, desvio_tomado}, {31'd0, m_taken});
         check("halt", {31'd0, halt}, {31'd0, m_halt});
      end
   end

   task automatic drive_random();
      branch      = 1'($urandom);
      zero        = 1'($urandom);
      funct3      = 3'($urandom);
      entrada_mux = $urandom;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) begin
         drive_random();
         @(negedge clock);
      end
      reset = 1'b0;
   endtask

   // One instruction: given inputs during the decision phase, noise elsewhere.
   // Returns the DUT's desvio_tomado as seen in phase 6.
   task automatic do_instr(input logic br, input logic [2:0] f3, input logic z,
                           input logic [31:0] tgt, output logic d6);
      bit done = 1'b0;
      d6 = 1'bx;
      for (int i = 0; i < 12 && !done && !m_halt; i++) begin
         if (m_fase == 5) begin
            branch = br; funct3 = f3; zero = z; entrada_mux = tgt;
         end else begin
            drive_random();
         end
         @(negedge clock);
         if (m_fase == 6) d6 = desvio_tomado;
         if (m_fase == 0 || m_halt) done = 1'b1;
      end
      if (!done && !m_halt) check("instr_timeout", 32'd0, 32'd1);
   endtask

   task automatic plain(input int n);
      logic d;
      repeat (n) do_instr(1'b0, 3'd0, 1'b0, 32'd0, d);
   endtask

   logic d6;

   initial begin
      // Reset and free run.
      do_reset(2);
      started = 1'b1;
      check("rst_pc", estado_pc, 32'd0);
      check("rst_fase", {28'd0, fase}, 32'd0);
      check("rst_desvio", {31'd0, desvio_tomado}, 32'd0);
      check("rst_halt", {31'd0, halt}, 32'd0);
      plain(3);
      check("free_run_pc", estado_pc, 32'd3);

      // beq taken from PC 3 to 10.
      do_instr(1'b1, 3'b000, 1'b1, 32'd10, d6);
      check("beq_desvio_ph6", {31'd0, d6}, 32'd1);
      check("beq_taken_pc", estado_pc, 32'd10);

      // beq not taken from PC 3.
      do_reset(1);
      plain(3);
      do_instr(1'b1, 3'b000, 1'b0, 32'd10, d6);
      check("beq_nt_desvio_ph6", {31'd0, d6}, 32'd0);
      check("beq_nt_pc", estado_pc, 32'd4);

      // bne taken from PC 2, then unsupported funct3.
      do_reset(1);
      plain(2);
      do_instr(1'b1, 3'b001, 1'b0, 32'd7, d6);
      check("bne_pc", estado_pc, 32'd7);
      do_instr(1'b1, 3'b100, 1'b1, 32'd20, d6);
      check("f3_100_pc", estado_pc, 32'd8);

      // Self-loop at PC 5.
      do_reset(1);
      plain(5);
      repeat (3) do_instr(1'b1, 3'b000, 1'b1, 32'd5, d6);
      check("selfloop_pc", estado_pc, 32'd5);
      check("selfloop_halt", {31'd0, halt}, 32'd0);

      // Reset at phase 9 of a taken branch to 12.
      do_reset(1);
      for (int i = 0; i < 12 && m_fase != 9; i++) begin
         if (m_fase == 5) begin
            branch = 1'b1; funct3 = 3'b000; zero = 1'b1; entrada_mux = 32'd12;
         end else drive_random();
         @(negedge clock);
      end
      check("midop_at_ph9", 32'(m_fase), 32'd9);
      do_reset(1);
      check("midop_pc", estado_pc, 32'd0);
      check("midop_fase", {28'd0, fase}, 32'd0);
      check("midop_desvio", {31'd0, desvio_tomado}, 32'd0);

      // Halt at PC_MAX with no branch, held for 20 cycles.
      do_instr(1'b1, 3'b000, 1'b1, 32'd31, d6);
      check("to31_pc", estado_pc, 32'd31);
      plain(1);
      repeat (20) begin
         drive_random();
         @(negedge clock);
      end
      check("max_halt", {31'd0, halt}, 32'd1);
      check("max_pc", estado_pc, 32'd31);
      check("max_fase", {28'd0, fase}, 32'd9);
      do_reset(1);
      check("halt_rst_halt", {31'd0, halt}, 32'd0);
      check("halt_rst_pc", estado_pc, 32'd0);

      // Wrapped negative target from PC 1.
      plain(1);
      do_instr(1'b1, 3'b000, 1'b1, 32'hFFFF_FFFE, d6);
      check("neg_halt", {31'd0, halt}, 32'd1);
      check("neg_pc", estado_pc, 32'd1);

      // Randomized instructions, reset whenever the model halts.
      do_reset(1);
      repeat (60) begin
         if (m_halt) do_reset(1 + int'($urandom_range(0, 1)));
         do_instr(1'($urandom), 3'($urandom_range(0, 2)), 1'($urandom),
                  ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 34)), d6);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
